// File: rtl/cache_ctrl_wb.sv
// L1 cache controller FSM: write-back eviction, write upgrades, line flush,
// snoop servicing (optional MOESI Owned) and ACE request timeout with bounded retry.
module cache_ctrl_wb #(
    parameter int WIDTH_STATE    = 3,
    parameter int MOESI_EN       = 0,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             cpu_request,
    output logic                   cache_ready,
    output logic                   cache_complete,
    output logic                   cache_error,
    input  logic                   cache_hit,
    input  logic                   cache_miss,
    input  logic [WIDTH_STATE-1:0] line_state,
    output logic                   write_from_cpu,
    output logic                   write_from_interconnect,
    output logic                   state_update,
    output logic [WIDTH_STATE-1:0] new_state,
    output logic                   read_req,
    output logic                   write_req,
    output logic                   invalid_req,
    output logic                   req_unique,
    input  logic                   ace_ready,
    input  logic                   ace_shared,
    input  logic                   snoop_valid,
    input  logic                   snoop_inv,
    output logic                   snoop_ack,
    output logic                   snoop_pass_dirty
);
    localparam logic [WIDTH_STATE-1:0] LS_I = WIDTH_STATE'(0);
    localparam logic [WIDTH_STATE-1:0] LS_S = WIDTH_STATE'(1);
    localparam logic [WIDTH_STATE-1:0] LS_E = WIDTH_STATE'(2);
    localparam logic [WIDTH_STATE-1:0] LS_M = WIDTH_STATE'(3);
    localparam logic [WIDTH_STATE-1:0] LS_O = WIDTH_STATE'(4);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [1:0] REQ_RD = 2'b01, REQ_WR = 2'b10, REQ_FL = 2'b11;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, EVICT, FILL, UPGRADE, UPDATE, SNOOP, COMPLETE, ERROR
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      req_q, req_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            drop_q, drop_d;
    logic            dirty, ace_wait, req_on;

    assign dirty    = (line_state == LS_M) || (line_state == LS_O);
    assign ace_wait = (state_q == EVICT) || (state_q == FILL) || (state_q == UPGRADE);
    assign req_on   = ace_wait && !drop_q;

    always_comb begin
        state_d                 = state_q;
        req_d                   = req_q;
        wait_d                  = wait_q;
        retry_d                 = retry_q;
        drop_d                  = 1'b0;
        cache_ready             = (state_q == IDLE) && !snoop_valid;
        cache_complete          = 1'b0;
        cache_error             = 1'b0;
        write_from_cpu          = 1'b0;
        write_from_interconnect = 1'b0;
        state_update            = 1'b0;
        new_state               = LS_I;
        read_req                = req_on && (state_q == FILL);
        write_req               = req_on && (state_q == EVICT);
        invalid_req             = req_on && (state_q == UPGRADE);
        req_unique              = req_on && (state_q == FILL) && (req_q == REQ_WR);
        snoop_ack               = 1'b0;
        snoop_pass_dirty        = 1'b0;

        // Shared request/timeout bookkeeping; ace_ready wins over a same-cycle timeout.
        if (req_on) begin
            if (ace_ready) begin
                wait_d  = '0;
                retry_d = '0;
            end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                if (retry_q == RW'(MAX_RETRY)) begin
                    state_d = ERROR;
                end else begin
                    drop_d  = 1'b1;
                    retry_d = retry_q + 1'b1;
                    wait_d  = '0;
                end
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                wait_d  = '0;
                retry_d = '0;
                if (snoop_valid) begin
                    state_d = SNOOP;
                end else if (cpu_request != 2'b00) begin
                    req_d   = cpu_request;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit) begin
                    case (req_q)
                        REQ_WR:  state_d = (line_state == LS_M || line_state == LS_E) ? UPDATE : UPGRADE;
                        REQ_FL: begin
                            if (dirty) begin
                                state_d = EVICT;
                            end else begin
                                state_update = 1'b1;
                                new_state    = LS_I;
                                state_d      = COMPLETE;
                            end
                        end
                        default: state_d = COMPLETE;
                    endcase
                end else if (cache_miss) begin
                    if (req_q == REQ_FL) state_d = COMPLETE;
                    else                 state_d = dirty ? EVICT : FILL;
                end
            end
            EVICT: begin
                if (req_on && ace_ready) begin
                    if (req_q == REQ_FL) begin
                        state_update = 1'b1;
                        new_state    = LS_I;
                        state_d      = COMPLETE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (req_on && ace_ready) begin
                    write_from_interconnect = 1'b1;
                    state_update            = 1'b1;
                    if (req_q == REQ_WR) begin
                        new_state = LS_E;
                        state_d   = UPDATE;
                    end else begin
                        new_state = ace_shared ? LS_S : LS_E;
                        state_d   = COMPLETE;
                    end
                end
            end
            UPGRADE: if (req_on && ace_ready) state_d = UPDATE;
            UPDATE: begin
                write_from_cpu = 1'b1;
                state_update   = 1'b1;
                new_state      = LS_M;
                state_d        = COMPLETE;
            end
            SNOOP: begin
                snoop_ack = 1'b1;
                state_d   = IDLE;
                if (snoop_inv) begin
                    state_update     = (line_state != LS_I);
                    snoop_pass_dirty = dirty;
                end else if (line_state == LS_M) begin
                    state_update     = 1'b1;
                    new_state        = (MOESI_EN != 0) ? LS_O : LS_S;
                    snoop_pass_dirty = (MOESI_EN == 0);
                end else if (line_state == LS_E) begin
                    state_update = 1'b1;
                    new_state    = LS_S;
                end
            end
            COMPLETE: begin
                cache_complete = 1'b1;
                state_d        = IDLE;
            end
            ERROR: begin
                cache_complete = 1'b1;
                cache_error    = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 2'b00;
            wait_q  <= '0;
            retry_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            retry_q <= retry_d;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb: dut0 is MOESI off with a short timeout,
// dut1 is MOESI on and is checked only on the snoop-share-of-M step.
module tb_cache_ctrl_wb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cpu_request;
    logic       cache_hit, cache_miss, ace_ready, ace_shared, snoop_valid, snoop_inv;
    logic [2:0] line_state;

    logic cache_ready, cache_complete, cache_error, write_from_cpu, write_from_interconnect;
    logic state_update, read_req, write_req, invalid_req, req_unique, snoop_ack, snoop_pass_dirty;
    logic [2:0] new_state;

    logic cache_ready_1, cache_complete_1, cache_error_1, write_from_cpu_1, write_from_interconnect_1;
    logic state_update_1, read_req_1, write_req_1, invalid_req_1, req_unique_1, snoop_ack_1, snoop_pass_dirty_1;
    logic [2:0] new_state_1;

    logic [13:0] outs0;
    assign outs0 = {cache_complete, cache_error, write_from_cpu, write_from_interconnect, state_update,
                    new_state, read_req, write_req, invalid_req, req_unique, snoop_ack, snoop_pass_dirty};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_ctrl_wb #(.WIDTH_STATE(3), .MOESI_EN(0), .TIMEOUT_CYCLES(4), .MAX_RETRY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .cpu_request(cpu_request), .cache_ready(cache_ready),
        .cache_complete(cache_complete), .cache_error(cache_error), .cache_hit(cache_hit),
        .cache_miss(cache_miss), .line_state(line_state), .write_from_cpu(write_from_cpu),
        .write_from_interconnect(write_from_interconnect), .state_update(state_update),
        .new_state(new_state), .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
        .req_unique(req_unique), .ace_ready(ace_ready), .ace_shared(ace_shared),
        .snoop_valid(snoop_valid), .snoop_inv(snoop_inv), .snoop_ack(snoop_ack),
        .snoop_pass_dirty(snoop_pass_dirty));

    cache_ctrl_wb #(.WIDTH_STATE(3), .MOESI_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cpu_request(cpu_request), .cache_ready(cache_ready_1),
        .cache_complete(cache_complete_1), .cache_error(cache_error_1), .cache_hit(cache_hit),
        .cache_miss(cache_miss), .line_state(line_state), .write_from_cpu(write_from_cpu_1),
        .write_from_interconnect(write_from_interconnect_1), .state_update(state_update_1),
        .new_state(new_state_1), .read_req(read_req_1), .write_req(write_req_1), .invalid_req(invalid_req_1),
        .req_unique(req_unique_1), .ace_ready(ace_ready), .ace_shared(ace_shared),
        .snoop_valid(snoop_valid), .snoop_inv(snoop_inv), .snoop_ack(snoop_ack_1),
        .snoop_pass_dirty(snoop_pass_dirty_1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1; checks happen at posedge+3 after settling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0; cpu_request = 2'b00; cache_hit = 1'b0; cache_miss = 1'b0; line_state = 3'd0;
        ace_ready = 1'b0; ace_shared = 1'b0; snoop_valid = 1'b0; snoop_inv = 1'b0;

        // Reset values
        settle();
        chk("rst_ready", 32'(cache_ready), 1);
        chk("rst_outs_zero", 32'(outs0), 0);
        snoop_valid = 1'b1; settle();
        chk("rst_ready_snoop", 32'(cache_ready), 0);
        snoop_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Snoop share on M with a simultaneous CPU read: snoop goes first
        snoop_valid = 1'b1; snoop_inv = 1'b0; cpu_request = 2'b01; settle();
        chk("snp_ready_low", 32'(cache_ready), 0);
        tick();
        line_state = 3'd3; settle();
        chk("snp_m_ack", 32'(snoop_ack), 1);
        chk("snp_m_pass", 32'(snoop_pass_dirty), 1);
        chk("snp_m_su", 32'(state_update), 1);
        chk("snp_m_ns", 32'(new_state), 1);
        chk("snp_m_ack_moesi", 32'(snoop_ack_1), 1);
        chk("snp_m_ns_moesi", 32'(new_state_1), 4);
        chk("snp_m_pass_moesi", 32'(snoop_pass_dirty_1), 0);
        tick();
        snoop_valid = 1'b0; settle();
        chk("snp_ready_back", 32'(cache_ready), 1);
        tick();
        // Read hit: complete two cycles after acceptance
        cpu_request = 2'b00; cache_hit = 1'b1; line_state = 3'd1;
        tick();
        cache_hit = 1'b0; settle();
        chk("rdhit_complete", 32'(cache_complete), 1);
        chk("rdhit_error", 32'(cache_error), 0);
        tick();

        // Read miss, clean victim, ace_ready 3 cycles after read_req, shared fill
        cpu_request = 2'b01; tick();
        cpu_request = 2'b00; cache_miss = 1'b1; line_state = 3'd2; tick();
        cache_miss = 1'b0; settle();
        chk("rdmiss_rr", 32'(read_req), 1);
        chk("rdmiss_unique", 32'(req_unique), 0);
        chk("rdmiss_wr", 32'(write_req), 0);
        tick(); tick(); tick();
        ace_ready = 1'b1; ace_shared = 1'b1; settle();
        chk("rdmiss_wfi", 32'(write_from_interconnect), 1);
        chk("rdmiss_su", 32'(state_update), 1);
        chk("rdmiss_ns", 32'(new_state), 1);
        tick();
        ace_ready = 1'b0; ace_shared = 1'b0; settle();
        chk("rdmiss_complete", 32'(cache_complete), 1);
        chk("rdmiss_wfi_off", 32'(write_from_interconnect), 0);
        tick();

        // Write miss on dirty victim: evict, ReadUnique fill, update
        cpu_request = 2'b10; tick();
        cpu_request = 2'b00; cache_miss = 1'b1; line_state = 3'd3; tick();
        cache_miss = 1'b0; settle();
        chk("wrmiss_evict_wr", 32'(write_req), 1);
        chk("wrmiss_evict_rr", 32'(read_req), 0);
        tick();
        ace_ready = 1'b1; settle();
        chk("wrmiss_evict_su", 32'(state_update), 0);
        tick();
        ace_ready = 1'b0; settle();
        chk("wrmiss_fill_rr", 32'(read_req), 1);
        chk("wrmiss_fill_unique", 32'(req_unique), 1);
        chk("wrmiss_fill_wr", 32'(write_req), 0);
        tick();
        ace_ready = 1'b1; ace_shared = 1'b1; settle();
        chk("wrmiss_fill_wfi", 32'(write_from_interconnect), 1);
        chk("wrmiss_fill_ns", 32'(new_state), 2);
        tick();
        ace_ready = 1'b0; ace_shared = 1'b0; settle();
        chk("wrmiss_upd_wfc", 32'(write_from_cpu), 1);
        chk("wrmiss_upd_ns", 32'(new_state), 3);
        tick(); settle();
        chk("wrmiss_complete", 32'(cache_complete), 1);
        tick();

        // Write hit on S: upgrade then update
        cpu_request = 2'b10; tick();
        cpu_request = 2'b00; cache_hit = 1'b1; line_state = 3'd1; tick();
        cache_hit = 1'b0; settle();
        chk("wrhit_s_ir", 32'(invalid_req), 1);
        ace_ready = 1'b1; tick();
        ace_ready = 1'b0; settle();
        chk("wrhit_s_wfc", 32'(write_from_cpu), 1);
        chk("wrhit_s_ns", 32'(new_state), 3);
        chk("wrhit_s_ir_off", 32'(invalid_req), 0);
        tick(); settle();
        chk("wrhit_s_complete", 32'(cache_complete), 1);
        tick();

        // Write hit on M: UPDATE in cycle 2, complete in cycle 3
        cpu_request = 2'b10; tick();
        cpu_request = 2'b00; cache_hit = 1'b1; line_state = 3'd3; tick();
        cache_hit = 1'b0; settle();
        chk("wrhit_m_upd", 32'(outs0), 32'b00101_011_000000);
        tick(); settle();
        chk("wrhit_m_complete", 32'(cache_complete), 1);
        tick();

        // Flush hit on clean line: invalidate in LOOKUP then complete
        cpu_request = 2'b11; tick();
        cpu_request = 2'b00; cache_hit = 1'b1; line_state = 3'd2; settle();
        chk("flush_clean_su", 32'(state_update), 1);
        chk("flush_clean_ns", 32'(new_state), 0);
        tick();
        cache_hit = 1'b0; settle();
        chk("flush_clean_complete", 32'(cache_complete), 1);
        tick();

        // Snoop invalidate on O line; snoop share on E line
        snoop_valid = 1'b1; snoop_inv = 1'b1; tick();
        line_state = 3'd4; settle();
        chk("snp_inv_o", 32'(outs0), 32'b00001_000_000011);
        tick();
        snoop_inv = 1'b0; tick();
        line_state = 3'd2; settle();
        chk("snp_shr_e", 32'(outs0), 32'b00001_001_000010);
        tick();
        snoop_valid = 1'b0; tick();

        // Timeout: 4 high, 1 low, 4 high, then error completion
        cpu_request = 2'b01; tick();
        cpu_request = 2'b00; cache_miss = 1'b1; line_state = 3'd0; tick();
        cache_miss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle(); chk($sformatf("to_rr_first_%0d", i), 32'(read_req), 1); tick();
        end
        settle(); chk("to_rr_drop", 32'(read_req), 0); tick();
        for (int i = 0; i < 4; i++) begin
            settle(); chk($sformatf("to_rr_second_%0d", i), 32'(read_req), 1); tick();
        end
        settle();
        chk("to_error_outs", 32'(outs0), 32'b11000_000_000000);
        tick(); settle();
        chk("to_idle_ready", 32'(cache_ready), 1);
        tick();

        // Reset in FILL aborts without completion
        cpu_request = 2'b01; tick();
        cpu_request = 2'b00; cache_miss = 1'b1; tick();
        cache_miss = 1'b0; settle();
        chk("rstfill_rr_before", 32'(read_req), 1);
        rst_n = 1'b0; #1;
        chk("rstfill_rr_drop", 32'(read_req), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("rstfill_ready_%0d", i), 32'(cache_ready), 1);
            chk($sformatf("rstfill_nocomplete_%0d", i), 32'(cache_complete), 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
